// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcm_pkg
// Description : Shared definitions for the PCM player: fetch FSM state
//               encoding, playback-rate clamp constant, volume gain table
//               and small sample helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pcm_pkg;

  // Fetch sequencer states. Bracketed states of the fetch sequence are
  // skipped according to the sample format latched at fetch start.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_L_LO   = 3'd1,
    ST_L_HI   = 3'd2,
    ST_R_LO   = 3'd3,
    ST_R_HI   = 3'd4,
    ST_UPDATE = 3'd5
  } state_t;

  // Largest effective rate increment: one fetch per output slot.
  localparam logic [7:0] RATE_MAX = 8'd128;

  // Gain in 1/128 units, index 0 mutes, index 15 is unity. Monotonic.
  localparam logic [7:0] VOL_GAIN [0:15] = '{
    8'd0,   8'd1,   8'd2,   8'd4,
    8'd8,   8'd12,  8'd16,  8'd24,
    8'd32,  8'd48,  8'd64,  8'd80,
    8'd96,  8'd104, 8'd112, 8'd128
  };

  function automatic logic [7:0] clamp_rate(input logic [7:0] r);
    return (r > RATE_MAX) ? RATE_MAX : r;
  endfunction

  // 8-bit samples are signed and left-justified; 16-bit samples arrive
  // low byte first.
  function automatic logic [15:0] build_sample(input logic [7:0] lo,
                                               input logic [7:0] hi,
                                               input logic       is16);
    return is16 ? {hi, lo} : {lo, 8'h00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_player_volume.sv
`default_nettype none
// ============================================================================
// Module      : pcm_volume
// Description : Per-channel gain stage with a single output register.
//               The register loads only on 'load', so the output holds
//               the last complete sample between updates.
//               Build option PCM_VOLUME_EN: when defined, the output is
//               (sample * VOL_GAIN[volume]) >>> 7; when undefined, volume
//               is ignored and the sample passes at unity with the same
//               one-register latency and no multiplier.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               load            - capture a new sample this cycle
//               sample_in [15:0]- signed input sample
//               volume [3:0]    - gain index
//               sample_out[15:0]- registered signed output
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_volume
  import pcm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] sample_in,
  input  logic [3:0]  volume,
  output logic [15:0] sample_out
);

  logic [15:0] scaled;

`ifdef PCM_VOLUME_EN
  // 16-bit signed times 9-bit non-negative gain; bits [22:7] are the
  // result of the >>> 7, and unity gain (128) cannot overflow.
  logic signed [24:0] prod;
  logic               unused_prod;

  assign prod        = $signed(sample_in) * $signed({1'b0, VOL_GAIN[volume]});
  assign scaled      = prod[22:7];
  assign unused_prod = ^{prod[24:23], prod[6:0]};
`else
  logic unused_volume;

  assign scaled        = sample_in;
  assign unused_volume = ^volume;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out <= 16'h0000;
    end else if (load) begin
      sample_out <= scaled;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcm_player.sv
`default_nettype none
// ============================================================================
// Module      : pcm_player
// Description : PCM sample player. A fractional rate accumulator decides on
//               each DAC slot whether a new sample is fetched from a FWFT
//               byte FIFO. Samples may be 8-bit signed or 16-bit
//               little-endian, mono or interleaved stereo. Both channels
//               update together through per-channel gain stages.
//               Build option PCM_VOLUME_EN enables volume scaling (see
//               pcm_volume); otherwise samples pass at unity.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               next_sample       - DAC slot strobe
//               rate [7:0]        - playback increment (>128 clamps to 128)
//               mode_stereo       - interleaved L/R samples
//               mode_16bit        - 16-bit LE samples (else 8-bit signed)
//               volume [3:0]      - gain index
//               fifo_rddata [7:0] - FIFO head byte
//               fifo_empty        - FIFO has no byte
//               fifo_read         - pop head byte
//               left_audio [15:0] - signed left sample
//               right_audio[15:0] - signed right sample
//               underrun          - pulse on failed or dropped fetch
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_player
  import pcm_pkg::*;
#(
  parameter int ACC_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sample,
  input  logic [7:0]  rate,
  input  logic        mode_stereo,
  input  logic        mode_16bit,
  input  logic [3:0]  volume,
  input  logic [7:0]  fifo_rddata,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic [15:0] left_audio,
  output logic [15:0] right_audio,
  output logic        underrun
);

  // Sum is wide enough for the largest accumulator plus the clamped rate.
  localparam int SUM_W = ((ACC_WIDTH > 8) ? ACC_WIDTH : 8) + 1;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 lat_stereo;
  logic                 lat_16bit;
  logic [7:0]           l_lo, l_hi, r_lo, r_hi;

  logic [7:0]           rate_eff;
  logic [SUM_W-1:0]     sum;
  logic                 fetch_req;
  logic                 byte_state;
  logic                 load;
  logic [15:0]          sample_l;
  logic [15:0]          sample_r;

  assign rate_eff  = clamp_rate(rate);
  assign sum       = SUM_W'(acc) + SUM_W'(rate_eff);
  // Any bit above the fraction is a carry and requests a fetch.
  assign fetch_req = next_sample && (sum[SUM_W-1:ACC_WIDTH] != '0);

  assign byte_state = (state == ST_L_LO) || (state == ST_L_HI) ||
                      (state == ST_R_LO) || (state == ST_R_HI);

  // The FIFO is first-word-fall-through, so the pop must coincide with the
  // cycle in which the head byte is captured.
  assign fifo_read = byte_state && !fifo_empty;

  assign load     = (state == ST_UPDATE);
  assign sample_l = build_sample(l_lo, l_hi, lat_16bit);
  assign sample_r = lat_stereo ? build_sample(r_lo, r_hi, lat_16bit) : sample_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      lat_stereo <= 1'b0;
      lat_16bit  <= 1'b0;
      l_lo       <= 8'h00;
      l_hi       <= 8'h00;
      r_lo       <= 8'h00;
      r_hi       <= 8'h00;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (next_sample) begin
        acc <= sum[ACC_WIDTH-1:0];
      end

      // A request arriving while a fetch is in progress is lost.
      if (fetch_req && (state != ST_IDLE)) begin
        underrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            lat_stereo <= mode_stereo;
            lat_16bit  <= mode_16bit;
            state      <= ST_L_LO;
          end
        end

        // In every byte state an empty FIFO aborts the fetch; bytes
        // already popped are simply never used.
        ST_L_LO: begin
          if (fifo_empty) begin
            underrun <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            l_lo <= fifo_rddata;
            if (lat_16bit) begin
              state <= ST_L_HI;
            end else if (lat_stereo) begin
              state <= ST_R_LO;
            end else begin
              state <= ST_UPDATE;
            end
          end
        end

        ST_L_HI: begin
          if (fifo_empty) begin
            underrun <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            l_hi  <= fifo_rddata;
            state <= lat_stereo ? ST_R_LO : ST_UPDATE;
          end
        end

        ST_R_LO: begin
          if (fifo_empty) begin
            underrun <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            r_lo  <= fifo_rddata;
            state <= lat_16bit ? ST_R_HI : ST_UPDATE;
          end
        end

        ST_R_HI: begin
          if (fifo_empty) begin
            underrun <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            r_hi  <= fifo_rddata;
            state <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Both channels load on the same UPDATE cycle, so the pair changes
  // together one cycle later.
  pcm_volume u_vol_left (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .sample_in  (sample_l),
    .volume     (volume),
    .sample_out (left_audio)
  );

  pcm_volume u_vol_right (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .sample_in  (sample_r),
    .volume     (volume),
    .sample_out (right_audio)
  );

endmodule
`default_nettype wire

// File: tb/tb_pcm_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcm_player
// Description : Directed self-checking bench for pcm_player with a byte
//               FIFO model and a queue of expected {left,right} pairs.
//               Expectations follow PCM_VOLUME_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_sample;
  logic [7:0]  rate;
  logic        mode_stereo;
  logic        mode_16bit;
  logic [3:0]  volume;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty;
  logic        fifo_read;
  logic [15:0] left_audio;
  logic [15:0] right_audio;
  logic        underrun;

  int checks     = 0;
  int errors     = 0;
  int pop_count  = 0;
  int urun_count = 0;
  int p0, u0;

  logic [7:0]  fifo_q[$];
  logic [31:0] exp_q[$];

  pcm_player #(.ACC_WIDTH(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .rate        (rate),
    .mode_stereo (mode_stereo),
    .mode_16bit  (mode_16bit),
    .volume      (volume),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .fifo_read   (fifo_read),
    .left_audio  (left_audio),
    .right_audio (right_audio),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic refresh_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_rddata = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic flush();
    fifo_q.delete();
    refresh_fifo();
  endtask

  // FIFO model: a pop seen at the edge removes the head shortly after it.
  always @(posedge clk) begin
    if (underrun) urun_count++;
    if (fifo_read) begin
      #1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_count++;
      refresh_fifo();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe();
    @(negedge clk) next_sample = 1'b1;
    @(negedge clk) next_sample = 1'b0;
  endtask

  // Strobe, confirm the previous pair holds through UPDATE, then compare
  // the scoreboard head one cycle later.
  task automatic fetch_and_check(input string tag, input int nbytes,
                                 input logic [31:0] prev);
    logic [31:0] e;
    strobe();
    tick(nbytes);
    check({tag, "_hold"}, {left_audio, right_audio}, prev);
    tick(1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {left_audio, right_audio}, e);
    end
  endtask

  initial begin
    rst = 1'b1; next_sample = 1'b0; rate = 8'd0;
    mode_stereo = 1'b0; mode_16bit = 1'b0; volume = 4'd15;
    refresh_fifo();
    tick(3);
    check("rst_left",     {16'h0, left_audio},  32'h0);
    check("rst_right",    {16'h0, right_audio}, 32'h0);
    check("rst_read",     {31'h0, fifo_read},   32'h0);
    check("rst_underrun", {31'h0, underrun},    32'h0);
    @(negedge clk) rst = 1'b0;

    // 8-bit mono at full rate
    rate = 8'd128;
    push(8'h40);
    exp_q.push_back({16'h4000, 16'h4000});
    p0 = pop_count; u0 = urun_count;
    fetch_and_check("mono8", 1, 32'h0000_0000);
    check("mono8_pops", pop_count - p0, 1);
    check("mono8_urun", urun_count - u0, 0);

    // 16-bit stereo, little-endian, unity volume
    mode_stereo = 1'b1; mode_16bit = 1'b1;
    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    exp_q.push_back({16'h1234, 16'h5678});
    p0 = pop_count;
    fetch_and_check("st16", 4, 32'h4000_4000);
    check("st16_pops", pop_count - p0, 4);

    // 8-bit stereo with negative samples
    mode_16bit = 1'b0;
    push(8'h80); push(8'hC1);
    exp_q.push_back({16'h8000, 16'hC100});
    fetch_and_check("st8", 2, 32'h1234_5678);

    // volume 0
    mode_stereo = 1'b0; volume = 4'd0;
    push(8'h7F);
`ifdef PCM_VOLUME_EN
    exp_q.push_back(32'h0000_0000);
`else
    exp_q.push_back({16'h7F00, 16'h7F00});
`endif
    fetch_and_check("vol0", 1, 32'h8000_C100);
    volume = 4'd15;

    // rate 64: eight slots give four fetches
    rate = 8'd64;
    for (int i = 1; i <= 8; i++) push(8'(i));
    p0 = pop_count; u0 = urun_count;
    for (int i = 0; i < 8; i++) begin
      strobe();
      tick(4);
    end
    check("rate64_pops", pop_count - p0, 4);
    check("rate64_out",  {left_audio, right_audio}, {16'h0400, 16'h0400});
    check("rate64_urun", urun_count - u0, 0);

    // rate 0: no fetches
    rate = 8'd0;
    p0 = pop_count;
    for (int i = 0; i < 8; i++) begin
      strobe();
      tick(2);
    end
    check("rate0_pops", pop_count - p0, 0);
    check("rate0_out",  {left_audio, right_audio}, {16'h0400, 16'h0400});
    flush();

    // FIFO runs dry mid-fetch
    rate = 8'd128; mode_stereo = 1'b1; mode_16bit = 1'b1;
    push(8'hAA); push(8'hBB);
    p0 = pop_count; u0 = urun_count;
    strobe();
    tick(6);
    check("dry_pops", pop_count - p0, 2);
    check("dry_urun", urun_count - u0, 1);
    check("dry_out",  {left_audio, right_audio}, {16'h0400, 16'h0400});

    // second request while busy is dropped
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    p0 = pop_count; u0 = urun_count;
    @(negedge clk) next_sample = 1'b1;
    @(negedge clk);
    @(negedge clk) next_sample = 1'b0;
    tick(8);
    check("drop_pops", pop_count - p0, 4);
    check("drop_urun", urun_count - u0, 1);
    check("drop_out",  {left_audio, right_audio}, {16'h2211, 16'h4433});

    // reset during R_LO
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    p0 = pop_count;
    strobe();
    tick(2);
    check("rlo_read", {31'h0, fifo_read}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rstfetch_read", {31'h0, fifo_read}, 32'h0);
    check("rstfetch_out",  {left_audio, right_audio}, 32'h0);
    tick(1);
    check("rstfetch_pops", pop_count - p0, 2);
    @(negedge clk) rst = 1'b0;
    flush();

    // sequencer is idle and usable after the reset
    mode_stereo = 1'b0; mode_16bit = 1'b0;
    push(8'h11);
    exp_q.push_back({16'h1100, 16'h1100});
    fetch_and_check("post_rst", 1, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcm_player.md
PCM_PLAYER -- requirements
Module: pcm_player

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 7: rate accumulator fraction width; a carry out of this width requests one sample.
REQ-002 SHALL have port clk  in  1  system clock; all logic single clock domain.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port next_sample  in  1  one-cycle strobe from DAC interface: output sample slot elapsed.
REQ-005 SHALL have port rate  in  8  playback rate increment; 0 = stopped; values >128 treated as 128.
REQ-006 SHALL have port mode_stereo  in  1  1 = interleaved L/R samples.
REQ-007 SHALL have port mode_16bit  in  1  1 = 16-bit little-endian samples; 0 = 8-bit signed.
REQ-008 SHALL have port volume  in  4  playback gain index.
REQ-009 SHALL have port fifo_rddata  in  8  first-word-fall-through FIFO head byte, valid while fifo_empty=0.
REQ-010 SHALL have port fifo_empty  in  1  FIFO has no byte.
REQ-011 SHALL have port fifo_read  out  1  one-cycle pop of head byte.
REQ-012 SHALL have port left_audio  out  16  signed left sample to mixer/DAC.
REQ-013 SHALL have port right_audio  out  16  signed right sample.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse on failed or dropped fetch.

Function
REQ-015 SHALL on next_sample compute sum = acc + min(rate,128); acc <= low ACC_WIDTH bits; carry set -> fetch request.
REQ-016 SHALL give rate 128 one fetch per next_sample, rate 64 one per two, rate 0 none.
REQ-017 SHALL latch mode_stereo/mode_16bit at fetch start; mode changes mid-fetch take effect next fetch.
REQ-018 SHALL use FSM IDLE -> L_LO -> [L_HI] -> [R_LO -> R_HI] -> UPDATE -> IDLE; bracketed states per latched mode; bytes per fetch 1/2/2/4 (8M/8S/16M/16S).
REQ-019 SHALL read at most one byte per cycle: in each byte state, if fifo_empty=0, assert fifo_read and capture fifo_rddata that cycle.
REQ-020 SHALL on fifo_empty=1 in any byte state: no pop, abort to IDLE, pulse underrun, keep outputs at last complete sample; bytes already popped discarded.
REQ-021 SHALL expand 8-bit byte b to {b, 8'h00}; 16-bit sample = {hi, lo}, lo byte first.
REQ-022 SHALL drive right = left in mono.
REQ-023 SHALL update left_audio and right_audio together, registered, one cycle after UPDATE (never a half-updated pair).
REQ-024 SHALL, on a fetch request while FSM not IDLE, drop the request and pulse underrun; current fetch continues; acc still updates.

Reset
REQ-025 SHALL on rst clear acc to 0, FSM to IDLE, left_audio/right_audio to 0, fifo_read and underrun to 0.
REQ-026 SHALL abort any fetch immediately on rst assertion, with no further pops.

Configuration
REQ-027 SHALL with PCM_VOLUME_EN defined output (sample * VOL_GAIN[volume]) >>> 7, signed, VOL_GAIN[0]=0, VOL_GAIN[15]=128, monotonic.
REQ-028 SHALL without PCM_VOLUME_EN ignore volume and pass samples at unity, with identical latency and no multiplier.

Structure
REQ-029 SHALL take FSM state encodings, VOL_GAIN table and rate clamp constant 128 from shared package pcm_pkg.
REQ-030 SHALL place gain scaling in sub-module pcm_volume (one instance per channel, one register stage).

Verification
REQ-031 SHALL test rate=128, 8-bit mono, FIFO holds 0x40 -> one pop, left=right=0x4000 after UPDATE+1.
REQ-032 SHALL test 16-bit stereo, bytes 34 12 78 56, volume 15 -> four pops, left=0x1234, right=0x5678 same cycle.
REQ-033 SHALL test rate=64, 8 next_sample strobes, full FIFO -> exactly 4 fetches; rate=0 -> no pops.
REQ-034 SHALL test 16-bit stereo with only 2 bytes queued -> 2 pops, underrun pulse, outputs unchanged.
REQ-035 SHALL test volume 0 with PCM_VOLUME_EN -> outputs 0; without macro volume 0 -> unity sample.
REQ-036 SHALL test rst asserted during R_LO -> fifo_read low next cycle, outputs 0, FSM IDLE.
